// File: rtl/lc3_mem_arbiter.sv
// Arbitrates one variable-latency memory between the LC3 fetch and data ports.
// Optional macro LC3_ARB_TIMEOUT_EN adds an ack watchdog with a sticky arb_err flag.
module lc3_mem_arbiter #(
    parameter int AW           = 16,
    parameter int DW           = 16,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic          clock,
    input  logic          reset,
    input  logic [AW-1:0] pc,
    input  logic          instrmem_rd,
    output logic [DW-1:0] Instr_dout,
    output logic          complete_instr,
    input  logic          data_req,
    input  logic [AW-1:0] Data_addr,
    input  logic          Data_rd,
    input  logic [DW-1:0] Data_din,
    output logic [DW-1:0] Data_dout,
    output logic          complete_data,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    input  logic          mem_ack,
    output logic          arb_err
);

    typedef enum logic [1:0] {IDLE, I_BUSY, D_BUSY, DONE} state_t;

    localparam logic [3:0]    LIMIT      = 4'(STARVE_LIMIT);
    localparam logic [DW-1:0] FAULT_WORD = DW'(16'hDEAD);

    state_t     state;
    logic [3:0] starve_cnt;
    logic       access_rd;
    logic       grant_data;
    logic       timed_out;

    // Data wins unless a fetch has already waited through LIMIT data grants.
    assign grant_data = data_req && (!instrmem_rd || (starve_cnt < LIMIT));

`ifdef LC3_ARB_TIMEOUT_EN
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    logic [WAIT_W-1:0] wait_cnt;

    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT - 1));
`else
    // TIMEOUT is inert here; the wait never expires for any legal value.
    assign timed_out = (TIMEOUT < 1);
    assign arb_err   = 1'b0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            starve_cnt     <= 4'd0;
            access_rd      <= 1'b0;
            mem_req        <= 1'b0;
            mem_we         <= 1'b0;
            mem_addr       <= '0;
            mem_wdata      <= '0;
            Instr_dout     <= '0;
            Data_dout      <= '0;
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
`ifdef LC3_ARB_TIMEOUT_EN
            wait_cnt       <= '0;
            arb_err        <= 1'b0;
`endif
        end else begin
            complete_instr <= 1'b0;
            complete_data  <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_data) begin
                        state      <= D_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= ~Data_rd;
                        mem_addr   <= Data_addr;
                        mem_wdata  <= Data_din;
                        access_rd  <= Data_rd;
                        starve_cnt <= instrmem_rd ? starve_cnt + 4'd1 : 4'd0;
                    end else if (instrmem_rd) begin
                        state      <= I_BUSY;
                        mem_req    <= 1'b1;
                        mem_we     <= 1'b0;
                        mem_addr   <= pc;
                        mem_wdata  <= '0;
                        access_rd  <= 1'b1;
                        starve_cnt <= 4'd0;
                    end
                end
                I_BUSY: begin
                    if (mem_ack || timed_out) begin
                        state          <= DONE;
                        mem_req        <= 1'b0;
                        mem_we         <= 1'b0;
                        complete_instr <= 1'b1;
                        Instr_dout     <= mem_ack ? mem_rdata : FAULT_WORD;
                    end
                end
                D_BUSY: begin
                    if (mem_ack || timed_out) begin
                        state         <= DONE;
                        mem_req       <= 1'b0;
                        mem_we        <= 1'b0;
                        complete_data <= 1'b1;
                        if (access_rd) begin
                            Data_dout <= mem_ack ? mem_rdata : FAULT_WORD;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
`ifdef LC3_ARB_TIMEOUT_EN
            // Counts busy cycles without an ack; a timeout also latches the error flag.
            if ((state == I_BUSY || state == D_BUSY) && !mem_ack) begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
                if (timed_out) begin
                    arb_err <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
`endif
        end
    end

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Scoreboard bench for lc3_mem_arbiter: request agents, a memory responder,
// a transaction-level priority model and a completion monitor.
module tb_lc3_mem_arbiter;

    localparam int AW           = 16;
    localparam int DW           = 16;
    localparam int STARVE_LIMIT = 4;
    localparam int TIMEOUT      = 64;

    typedef struct {
        logic        rd;
        logic [15:0] addr;
        logic [15:0] din;
    } data_txn_t;

    typedef struct {
        logic        is_data;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] instr;
        logic [15:0] data;
    } exp_t;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [15:0] wdata;
    } grant_t;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] pc;
    logic          instrmem_rd;
    logic [DW-1:0] Instr_dout;
    logic          complete_instr;
    logic          data_req;
    logic [AW-1:0] Data_addr;
    logic          Data_rd;
    logic [DW-1:0] Data_din;
    logic [DW-1:0] Data_dout;
    logic          complete_data;
    logic          mem_req;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;
    logic          mem_ack;
    logic          arb_err;

    logic [15:0] fetch_q[$];
    data_txn_t   data_q[$];
    exp_t        sb_q[$];
    grant_t      grant_q[$];
    logic [15:0] plan_f[$];
    data_txn_t   plan_d[$];

    logic [15:0] env_mem[logic [15:0]];
    logic [15:0] model_mem[logic [15:0]];
    int          model_starve;
    logic [15:0] model_instr;
    logic [15:0] model_data;

    logic hold_ack  = 1'b0;
    logic force_ack = 1'b0;

    int n_vec     = 0;
    int n_miscmp  = 0;

    lc3_mem_arbiter #(
        .AW(AW), .DW(DW), .STARVE_LIMIT(STARVE_LIMIT), .TIMEOUT(TIMEOUT)
    ) dut (
        .clock(clock), .reset(reset),
        .pc(pc), .instrmem_rd(instrmem_rd), .Instr_dout(Instr_dout),
        .complete_instr(complete_instr),
        .data_req(data_req), .Data_addr(Data_addr), .Data_rd(Data_rd),
        .Data_din(Data_din), .Data_dout(Data_dout), .complete_data(complete_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
        .arb_err(arb_err)
    );

    always #5 clock = ~clock;

    function automatic logic [15:0] seed_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] model_read(input logic [15:0] a);
        return model_mem.exists(a) ? model_mem[a] : seed_word(a);
    endfunction

    function automatic logic [15:0] env_read(input logic [15:0] a);
        return env_mem.exists(a) ? env_mem[a] : seed_word(a);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miscmp++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Fetch agent: holds the request until its completion, then moves to the next pc.
    initial begin
        instrmem_rd = 1'b0;
        pc          = '0;
        forever begin
            @(negedge clock);
            if (instrmem_rd && complete_instr && fetch_q.size() > 0) void'(fetch_q.pop_front());
            if (fetch_q.size() > 0) begin
                instrmem_rd = 1'b1;
                pc          = fetch_q[0];
            end else begin
                instrmem_rd = 1'b0;
            end
        end
    end

    // Data agent: same handshake discipline for the data port.
    initial begin
        data_req  = 1'b0;
        Data_addr = '0;
        Data_rd   = 1'b1;
        Data_din  = '0;
        forever begin
            @(negedge clock);
            if (data_req && complete_data && data_q.size() > 0) void'(data_q.pop_front());
            if (data_q.size() > 0) begin
                data_req  = 1'b1;
                Data_addr = data_q[0].addr;
                Data_rd   = data_q[0].rd;
                Data_din  = data_q[0].din;
            end else begin
                data_req  = 1'b0;
            end
        end
    end

    // Memory responder: random ack latency, plus stray acks while no access is open.
    initial begin
        bit resp_busy = 0;
        bit resp_done = 0;
        int resp_wait = 0;
        mem_ack   = 1'b0;
        mem_rdata = '0;
        forever begin
            @(negedge clock);
            mem_ack = 1'b0;
            if (hold_ack) begin
                mem_ack   = force_ack;
                mem_rdata = 16'($urandom);
                resp_busy = 0;
                resp_done = 0;
            end else if (mem_req) begin
                if (!resp_busy) begin
                    resp_busy = 1;
                    resp_wait = int'($urandom_range(0, 3));
                end
                if (!resp_done) begin
                    if (resp_wait == 0) begin
                        mem_ack   = 1'b1;
                        resp_done = 1;
                        if (mem_we) begin
                            env_mem[mem_addr] = mem_wdata;
                            mem_rdata         = 16'($urandom);
                        end else begin
                            mem_rdata = env_read(mem_addr);
                        end
                    end else begin
                        resp_wait--;
                    end
                end
            end else begin
                resp_busy = 0;
                resp_done = 0;
                if ($urandom_range(0, 5) == 0) begin
                    mem_ack   = 1'b1;
                    mem_rdata = 16'($urandom);
                end
            end
        end
    end

    // Monitor: records each grant, pops the scoreboard on every completion.
    initial begin
        logic   prev_req  = 1'b0;
        logic   prev_cmp  = 1'b0;
        grant_t cur;
        grant_t g;
        exp_t   e;
        forever begin
            @(negedge clock);
            if (reset) begin
                prev_req = 1'b0;
                prev_cmp = 1'b0;
                grant_q.delete();
            end else begin
                if (mem_req && !prev_req) begin
                    cur = '{mem_addr, mem_we, mem_wdata};
                    grant_q.push_back(cur);
                end else if (mem_req) begin
                    checkOutput("mem_addr_stable", 32'(mem_addr), 32'(cur.addr));
                    checkOutput("mem_we_stable", 32'(mem_we), 32'(cur.we));
                end
                if (complete_instr || complete_data) begin
                    checkOutput("complete_exclusive", 32'(complete_instr & complete_data), 32'd0);
                    checkOutput("complete_width", 32'(prev_cmp), 32'd0);
                    checkOutput("mem_req_in_done", 32'(mem_req), 32'd0);
                    checkOutput("expected_pending", 32'(sb_q.size() > 0), 32'd1);
                    checkOutput("grant_pending", 32'(grant_q.size() > 0), 32'd1);
                    if (sb_q.size() > 0 && grant_q.size() > 0) begin
                        e = sb_q.pop_front();
                        g = grant_q.pop_front();
                        checkOutput("complete_kind", 32'(complete_data), 32'(e.is_data));
                        checkOutput("grant_addr", 32'(g.addr), 32'(e.addr));
                        checkOutput("grant_we", 32'(g.we), 32'(e.we));
                        if (e.we) checkOutput("grant_wdata", 32'(g.wdata), 32'(e.wdata));
                        checkOutput("Instr_dout", 32'(Instr_dout), 32'(e.instr));
                        checkOutput("Data_dout", 32'(Data_dout), 32'(e.data));
                    end
                end
                prev_req = mem_req;
                prev_cmp = complete_instr | complete_data;
            end
        end
    end

    task automatic resetDut();
        @(negedge clock);
        reset = 1'b1;
        fetch_q.delete();
        data_q.delete();
        sb_q.delete();
        repeat (2) @(negedge clock);
        reset        = 1'b0;
        model_starve = 0;
        model_instr  = '0;
        model_data   = '0;
    endtask

    // Predicts the completion order for the planned burst, then releases the agents together.
    task automatic applyStimulus();
        int        fi = 0;
        int        di = 0;
        exp_t      e;
        data_txn_t t;
        bit        f_pend;
        bit        d_pend;
        while (fi < plan_f.size() || di < plan_d.size()) begin
            f_pend = fi < plan_f.size();
            d_pend = di < plan_d.size();
            if (d_pend && (!f_pend || model_starve < STARVE_LIMIT)) begin
                model_starve = f_pend ? model_starve + 1 : 0;
                t = plan_d[di];
                di++;
                e.is_data = 1'b1;
                e.we      = !t.rd;
                e.addr    = t.addr;
                e.wdata   = t.din;
                if (t.rd) model_data = model_read(t.addr);
                else      model_mem[t.addr] = t.din;
            end else begin
                model_starve = 0;
                e.is_data    = 1'b0;
                e.we         = 1'b0;
                e.addr       = plan_f[fi];
                e.wdata      = '0;
                model_instr  = model_read(plan_f[fi]);
                fi++;
            end
            e.instr = model_instr;
            e.data  = model_data;
            sb_q.push_back(e);
        end
        @(posedge clock);
        #1;
        fetch_q = plan_f;
        data_q  = plan_d;
        for (int c = 0; c < 600 && (sb_q.size() > 0 || fetch_q.size() > 0 || data_q.size() > 0); c++)
            @(negedge clock);
        checkOutput("burst_drain", 32'(sb_q.size() + fetch_q.size() + data_q.size()), 32'd0);
        if (sb_q.size() > 0 || fetch_q.size() > 0 || data_q.size() > 0) resetDut();
        repeat (2) @(negedge clock);
    endtask

    task automatic randomBurst();
        int nf = int'($urandom_range(0, 3));
        int nd = int'($urandom_range(0, 6));
        if (nf + nd == 0) nd = 1;
        plan_f.delete();
        plan_d.delete();
        for (int i = 0; i < nf; i++) plan_f.push_back(16'h3000 + 16'($urandom_range(0, 7)));
        for (int i = 0; i < nd; i++)
            plan_d.push_back('{1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 7)),
                               16'($urandom)});
        applyStimulus();
    endtask

    initial begin
        reset        = 1'b1;
        model_starve = 0;
        model_instr  = '0;
        model_data   = '0;
        repeat (3) @(negedge clock);
        checkOutput("rst_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rst_mem_we", 32'(mem_we), 32'd0);
        checkOutput("rst_mem_addr", 32'(mem_addr), 32'd0);
        checkOutput("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        checkOutput("rst_Instr_dout", 32'(Instr_dout), 32'd0);
        checkOutput("rst_Data_dout", 32'(Data_dout), 32'd0);
        checkOutput("rst_complete_instr", 32'(complete_instr), 32'd0);
        checkOutput("rst_complete_data", 32'(complete_data), 32'd0);
        checkOutput("rst_arb_err", 32'(arb_err), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        env_mem[16'h3000]   = 16'h1261;
        model_mem[16'h3000] = 16'h1261;
        $display("[TB] fetch only");
        plan_f = '{16'h3000};
        plan_d.delete();
        applyStimulus();

        $display("[TB] fetch/data collision");
        plan_f = '{16'h3002};
        plan_d.delete();
        plan_d.push_back('{1'b1, 16'h4000, 16'h0000});
        applyStimulus();

        $display("[TB] write then read back");
        plan_f.delete();
        plan_d.delete();
        plan_d.push_back('{1'b0, 16'h4010, 16'hBEEF});
        plan_d.push_back('{1'b0, 16'h4011, 16'h1234});
        plan_d.push_back('{1'b1, 16'h4010, 16'h0000});
        applyStimulus();

        $display("[TB] starvation");
        plan_f = '{16'h3004, 16'h3005};
        plan_d.delete();
        for (int i = 0; i < 6; i++) plan_d.push_back('{1'b1, 16'h4000 + 16'(i), 16'h0000});
        applyStimulus();

        $display("[TB] random bursts");
        for (int b = 0; b < 30; b++) randomBurst();

        $display("[TB] reset during data access");
        hold_ack  = 1'b1;
        force_ack = 1'b0;
        @(posedge clock);
        #1;
        data_q.push_back('{1'b1, 16'h4020, 16'h0000});
        for (int c = 0; c < 20 && !mem_req; c++) @(negedge clock);
        checkOutput("rstmid_granted", 32'(mem_req), 32'd1);
        @(negedge clock);
        reset = 1'b1;
        data_q.delete();
        @(posedge clock);
        #1;
        checkOutput("rstmid_mem_req", 32'(mem_req), 32'd0);
        checkOutput("rstmid_complete_data", 32'(complete_data), 32'd0);
        checkOutput("rstmid_Data_dout", 32'(Data_dout), 32'd0);
        checkOutput("rstmid_Instr_dout", 32'(Instr_dout), 32'd0);
        checkOutput("rstmid_mem_addr", 32'(mem_addr), 32'd0);
        @(negedge clock);
        reset        = 1'b0;
        model_starve = 0;
        model_instr  = '0;
        model_data   = '0;
        @(posedge clock);
        #1;
        force_ack = 1'b1;
        @(posedge clock);
        #1;
        force_ack = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clock);
            checkOutput("late_ack_complete", 32'(complete_data | complete_instr), 32'd0);
            checkOutput("late_ack_mem_req", 32'(mem_req), 32'd0);
        end
        hold_ack = 1'b0;

        for (int b = 0; b < 10; b++) randomBurst();

`ifdef LC3_ARB_TIMEOUT_EN
        $display("[TB] ack timeout");
        hold_ack     = 1'b1;
        force_ack    = 1'b0;
        model_starve = 0;
        model_instr  = 16'hDEAD;
        sb_q.push_back('{1'b0, 1'b0, 16'h3100, 16'h0000, 16'hDEAD, model_data});
        @(posedge clock);
        #1;
        fetch_q.push_back(16'h3100);
        for (int c = 0; c < 200 && sb_q.size() > 0; c++) @(negedge clock);
        checkOutput("timeout_drain", 32'(sb_q.size()), 32'd0);
        checkOutput("timeout_arb_err", 32'(arb_err), 32'd1);
        hold_ack = 1'b0;
`else
        checkOutput("arb_err_tied", 32'(arb_err), 32'd0);
`endif

        repeat (3) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscmp);
        $finish;
    end

endmodule
